// File: rtl/io_pkg.sv
// ============================================================================
// Module      : io_pkg
// Description : Shared constants and types for the processor I/O ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package io_pkg;
  localparam int          IO_WIDTH    = 16;
  localparam int          IO_IN_DEPTH = 4;

  // Data-memory decoder address of the input port data/status registers
  localparam logic [15:0] IO_IN_ADDR      = 16'hFF10;
  localparam logic [15:0] IO_IN_STAT_ADDR = 16'hFF11;

  // Status word bit positions as seen by the processor: {underflow, full, empty}
  localparam int IO_IN_ST_EMPTY     = 0;
  localparam int IO_IN_ST_FULL      = 1;
  localparam int IO_IN_ST_UNDERFLOW = 2;

  typedef struct packed {
    logic underflow;
    logic full;
    logic empty;
  } io_in_status_t;
endpackage

`default_nettype wire

// File: rtl/sync_fifo_ptr.sv
// ============================================================================
// Module      : sync_fifo_ptr
// Description : FIFO pointer pair with full/empty and optional occupancy
//               count (count present only when IO_IN_COUNT_EN is defined).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_ptr #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  output logic [$clog2(DEPTH)-1:0] o_wr_idx,
  output logic [$clog2(DEPTH)-1:0] o_rd_idx,
  output logic                     o_empty,
  output logic                     o_full
`ifdef IO_IN_COUNT_EN
  ,output logic [$clog2(DEPTH):0]  o_count
`endif
);
  localparam int             c_aw  = $clog2(DEPTH);
  localparam logic [c_aw:0]  c_one = (c_aw + 1)'(1);

  // Extra MSB on each pointer separates the full and empty cases
  logic [c_aw:0] r_wp;
  logic [c_aw:0] r_rp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (i_push) r_wp <= r_wp + c_one;
      if (i_pop)  r_rp <= r_rp + c_one;
    end
  end

  assign o_wr_idx = r_wp[c_aw-1:0];
  assign o_rd_idx = r_rp[c_aw-1:0];
  assign o_empty  = (r_wp == r_rp);
  assign o_full   = (r_wp[c_aw] != r_rp[c_aw]) &&
                    (r_wp[c_aw-1:0] == r_rp[c_aw-1:0]);
`ifdef IO_IN_COUNT_EN
  assign o_count  = r_wp - r_rp;
`endif
endmodule

`default_nettype wire

// File: rtl/io_in_port.sv
// ============================================================================
// Module      : io_in_port
// Description : Memory-mapped input port: valid/ready producer into a small
//               FIFO, drained by a one-cycle processor read strobe.
//               Optional occupancy port enabled by IO_IN_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_in_port
  import io_pkg::*;
#(
  parameter int WIDTH = IO_WIDTH,
  parameter int DEPTH = IO_IN_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic                     underflow,
  input  logic                     clr_err
`ifdef IO_IN_COUNT_EN
  ,output logic [$clog2(DEPTH):0]  count
`endif
);
  localparam int c_aw = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;
  logic             r_underflow;
  logic [c_aw-1:0]  w_wr_idx;
  logic [c_aw-1:0]  w_rd_idx;
  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic             w_uflow;

  assign w_push  = in_valid && !w_full;
  assign w_pop   = rd_en && !w_empty;
  assign w_uflow = rd_en && w_empty;

  sync_fifo_ptr #(
    .DEPTH    (DEPTH)
  ) u_ptr (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_push   (w_push),
    .i_pop    (w_pop),
    .o_wr_idx (w_wr_idx),
    .o_rd_idx (w_rd_idx),
    .o_empty  (w_empty),
    .o_full   (w_full)
`ifdef IO_IN_COUNT_EN
    ,.o_count (count)
`endif
  );

  // Storage needs no reset: contents are only observable through the pointers
  always_ff @(posedge clk) begin
    if (w_push) r_mem[w_wr_idx] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data   <= '0;
      r_underflow <= 1'b0;
    end else begin
      if (w_pop) r_rd_data <= r_mem[w_rd_idx];
      if (w_uflow)      r_underflow <= 1'b1;
      else if (clr_err) r_underflow <= 1'b0;
    end
  end

  assign in_ready  = !w_full;
  assign rd_data   = r_rd_data;
  assign empty     = w_empty;
  assign full      = w_full;
  assign underflow = r_underflow;
endmodule

`default_nettype wire

// File: tb/tb_io_in_port.sv
// ============================================================================
// Module      : tb_io_in_port
// Description : Self-checking bench for io_in_port (count checks compiled in
//               only when IO_IN_COUNT_EN is defined).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_io_in_port;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        rd_en;
  logic [15:0] rd_data;
  logic        empty;
  logic        full;
  logic        underflow;
  logic        clr_err;
`ifdef IO_IN_COUNT_EN
  logic [2:0]  count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [15:0] din;
    logic        vld;
    logic        rd;
    logic        clr;
    logic [15:0] e_rd;
    logic        e_empty;
    logic        e_full;
    logic        e_ready;
    logic        e_uf;
    int          e_cnt;
  } vec_t;

  vec_t        vecs [17];
  logic [15:0] model [$];

  io_in_port dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (full),
    .underflow (underflow),
    .clr_err   (clr_err)
`ifdef IO_IN_COUNT_EN
    ,.count    (count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, time=%0t required < 200000", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_cnt(input string name, input int exp);
`ifdef IO_IN_COUNT_EN
    check(name, 32'(count), 32'(exp));
`endif
  endtask

  task automatic step(input logic [15:0] d, input logic v, input logic r, input logic c);
    @(negedge clk);
    in_data  = d;
    in_valid = v;
    rd_en    = r;
    clr_err  = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //                din      vld   rd    clr   e_rd     emp   full  rdy   uf  cnt
    vecs[0]  = '{16'h1111, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    vecs[1]  = '{16'h2222, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 2};
    vecs[2]  = '{16'h3333, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 3};
    vecs[3]  = '{16'h4444, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 4};
    vecs[4]  = '{16'hDEAD, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 4};
    vecs[5]  = '{16'hDEAD, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 4};
    vecs[6]  = '{16'h0000, 1'b0, 1'b1, 1'b0, 16'h1111, 1'b0, 1'b0, 1'b1, 1'b0, 3};
    vecs[7]  = '{16'h0000, 1'b0, 1'b1, 1'b0, 16'h2222, 1'b0, 1'b0, 1'b1, 1'b0, 2};
    vecs[8]  = '{16'h0000, 1'b0, 1'b1, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    vecs[9]  = '{16'h0000, 1'b0, 1'b1, 1'b0, 16'h4444, 1'b1, 1'b0, 1'b1, 1'b0, 0};
    vecs[10] = '{16'h0000, 1'b0, 1'b0, 1'b0, 16'h4444, 1'b1, 1'b0, 1'b1, 1'b0, 0};
    vecs[11] = '{16'h0000, 1'b0, 1'b1, 1'b0, 16'h4444, 1'b1, 1'b0, 1'b1, 1'b1, 0};
    vecs[12] = '{16'h0000, 1'b0, 1'b0, 1'b0, 16'h4444, 1'b1, 1'b0, 1'b1, 1'b1, 0};
    vecs[13] = '{16'h0000, 1'b0, 1'b0, 1'b1, 16'h4444, 1'b1, 1'b0, 1'b1, 1'b0, 0};
    vecs[14] = '{16'h0000, 1'b0, 1'b1, 1'b1, 16'h4444, 1'b1, 1'b0, 1'b1, 1'b1, 0};
    // Push and read together while empty: push lands, read is an underflow
    vecs[15] = '{16'h5555, 1'b1, 1'b1, 1'b1, 16'h4444, 1'b0, 1'b0, 1'b1, 1'b1, 1};
    vecs[16] = '{16'h0000, 1'b0, 1'b1, 1'b1, 16'h5555, 1'b1, 1'b0, 1'b1, 1'b0, 0};

    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset empty", 32'(empty), 32'd1);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset full", 32'(full), 32'd0);
    check("reset rd_data", 32'(rd_data), 32'h0);
    check("reset underflow", 32'(underflow), 32'd0);
    check_cnt("reset count", 0);

    for (int i = 0; i < 17; i++) begin
      step(vecs[i].din, vecs[i].vld, vecs[i].rd, vecs[i].clr);
      check($sformatf("vec%0d rd_data", i), 32'(rd_data), 32'(vecs[i].e_rd));
      check($sformatf("vec%0d empty", i), 32'(empty), 32'(vecs[i].e_empty));
      check($sformatf("vec%0d full", i), 32'(full), 32'(vecs[i].e_full));
      check($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].e_ready));
      check($sformatf("vec%0d underflow", i), 32'(underflow), 32'(vecs[i].e_uf));
      check_cnt($sformatf("vec%0d count", i), vecs[i].e_cnt);
    end

    // Simultaneous push/pop at occupancy 2, crossing the pointer wrap
    for (int i = 0; i < 10; i++) begin
      logic [15:0] w;
      logic [15:0] exp_w;
      w = 16'hA000 + 16'(i);
      step(w, 1'b1, (i >= 2), 1'b0);
      model.push_back(w);
      if (i >= 2) begin
        exp_w = model.pop_front();
        check($sformatf("pp%0d rd_data", i), 32'(rd_data), 32'(exp_w));
      end
      if (i >= 1) check_cnt($sformatf("pp%0d count", i), 2);
      check($sformatf("pp%0d empty", i), 32'(empty), 32'd0);
    end
    for (int i = 0; i < 2; i++) begin
      logic [15:0] exp_w;
      step(16'h0, 1'b0, 1'b1, 1'b0);
      exp_w = model.pop_front();
      check($sformatf("drain%0d rd_data", i), 32'(rd_data), 32'(exp_w));
    end
    check("drain empty", 32'(empty), 32'd1);
    check("drain underflow", 32'(underflow), 32'd0);

    // Asynchronous reset with three words stored
    for (int i = 0; i < 3; i++) step(16'hB000 + 16'(i), 1'b1, 1'b0, 1'b0);
    check("pre-reset empty", 32'(empty), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async reset empty", 32'(empty), 32'd1);
    check("async reset in_ready", 32'(in_ready), 32'd1);
    check("async reset full", 32'(full), 32'd0);
    check("async reset rd_data", 32'(rd_data), 32'h0);
    check_cnt("async reset count", 0);
    #1 rst_n = 1'b1;
    step(16'hC000, 1'b1, 1'b0, 1'b0);
    step(16'hC001, 1'b1, 1'b0, 1'b0);
    check_cnt("post-reset count", 2);
    step(16'h0, 1'b0, 1'b1, 1'b0);
    check("post-reset rd0", 32'(rd_data), 32'hC000);
    step(16'h0, 1'b0, 1'b1, 1'b0);
    check("post-reset rd1", 32'(rd_data), 32'hC001);
    check("post-reset empty", 32'(empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

`default_nettype wire
